// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the multicycle sequencer.
//   - 3-bit state encodings and the typed state enum built from them
//   - RV32 major opcode constants
//   - is_known_op(): true for the opcodes the sequencer recognises
package proc_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef enum logic [2:0] {
    StFetch  = ST_FETCH,
    StDecode = ST_DECODE,
    StExec   = ST_EXEC,
    StMem    = ST_MEM,
    StWb     = ST_WB,
    StErr    = ST_ERR
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic is_known_op(input logic [6:0] op);
    logic known;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: known = 1'b1;
      default:                                                    known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: instruction/data memory handshake bundle.
//   IMEM_REQ  sequencer -> imem  fetch request, held until IMEM_ACK
//   IMEM_ACK  imem -> sequencer  fetch acknowledge (honoured only while IMEM_REQ=1)
//   DMEM_REQ  sequencer -> dmem  data access request, held until DMEM_ACK
//   DMEM_WE   sequencer -> dmem  1 = store, 0 = load (valid with DMEM_REQ)
//   DMEM_ACK  dmem -> sequencer  data acknowledge (honoured only while DMEM_REQ=1)
// master: the sequencer side; slave: the memory side.
interface multicycle_sequencer_if;

  logic IMEM_REQ;
  logic IMEM_ACK;
  logic DMEM_REQ;
  logic DMEM_WE;
  logic DMEM_ACK;

  modport master (
    output IMEM_REQ,
    output DMEM_REQ,
    output DMEM_WE,
    input  IMEM_ACK,
    input  DMEM_ACK
  );

  modport slave (
    input  IMEM_REQ,
    input  DMEM_REQ,
    input  DMEM_WE,
    output IMEM_ACK,
    output DMEM_ACK
  );

endinterface

// File: rtl/bus_timeout.sv
// bus_timeout: counts consecutive cycles in which a bus request is pending without
// acknowledge and flags expiry on the cycle the count would reach TIMEOUT_CYC.
// Only built with BUS_TIMEOUT_EN defined (the sequencer instantiates it only then).
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_start    first cycle of a waiting state: count restarts from zero
//   i_busy     request is asserted this cycle
//   i_ack      acknowledge this cycle (wins over expiry)
//   o_expired  this is the TIMEOUT_CYC-th consecutive unacknowledged cycle
`ifdef BUS_TIMEOUT_EN
module bus_timeout #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expired
);

  localparam logic [7:0] LastWait = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_eff;
  logic       w_waiting;

  // Entering a state discards any count left over from an earlier wait.
  assign w_cnt_eff = i_start ? 8'd0 : r_cnt;
  assign w_waiting = i_busy & ~i_ack;
  assign o_expired = w_waiting & (w_cnt_eff == LastWait);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 8'd0;
    end else if (w_waiting) begin
      r_cnt <= w_cnt_eff + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control sequencer for a multicycle core.
// Optional feature: define BUS_TIMEOUT_EN to add the bus-wait watchdog (ERR state,
// sticky BUS_ERR). Without it waits are unbounded and BUS_ERR is tied low.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   opcode            instruction-register opcode field
//   WE_Data_in        control unit: instruction stores to data memory
//   RE_Data_in        control unit: instruction loads from data memory
//   WE_Regs_in        control unit: instruction writes the register file
//   bus               memory handshake (master side)
//   IR_EN, MDR_EN     instruction-register load, load-data latch (1-cycle pulses)
//   PC_EN, WE_Regs    PC update, register-file write (1-cycle pulses)
//   INSTRET           retired-instruction count, +1 per PC_EN, wraps at 16 bits
//   BUS_ERR           sticky bus error
module multicycle_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [6:0]                    opcode,
  input  logic                          WE_Data_in,
  input  logic                          RE_Data_in,
  input  logic                          WE_Regs_in,
  multicycle_sequencer_if.master        bus,
  output logic                          IR_EN,
  output logic                          MDR_EN,
  output logic                          PC_EN,
  output logic                          WE_Regs,
  output logic [15:0]                   INSTRET,
  output logic                          BUS_ERR
);

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_instret;

  logic w_op_known;
  logic w_we_data;
  logic w_re_data;
  logic w_we_regs_in;
  logic w_expired;

  logic w_imem_req;
  logic w_dmem_req;
  logic w_dmem_we;
  logic w_ir_en;
  logic w_mdr_en;
  logic w_pc_en;
  logic w_we_regs;

  // Strobes from an unrecognised opcode are discarded so it always sequences as a no-op.
  assign w_op_known   = is_known_op(opcode);
  assign w_we_data    = WE_Data_in & w_op_known;
  assign w_re_data    = RE_Data_in & w_op_known;
  assign w_we_regs_in = WE_Regs_in & w_op_known;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and raw (pre-reset-gating) outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_ir_en      = 1'b0;
    w_mdr_en     = 1'b0;
    w_pc_en      = 1'b0;
    w_we_regs    = 1'b0;

    unique case (r_state)
      StFetch: begin
        w_imem_req = 1'b1;
        if (bus.IMEM_ACK) begin
          w_ir_en      = 1'b1;
          w_state_next = StDecode;
        end else if (w_expired) begin
          w_state_next = StErr;
        end
      end

      StDecode: begin
        w_state_next = StExec;
      end

      StExec: begin
        if (w_we_data | w_re_data) begin
          w_state_next = StMem;
        end else if (w_we_regs_in) begin
          w_state_next = StWb;
        end else begin
          w_pc_en      = 1'b1;
          w_state_next = StFetch;
        end
      end

      StMem: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_we_data;
        if (bus.DMEM_ACK) begin
          if (w_re_data) begin
            w_mdr_en     = 1'b1;
            w_state_next = StWb;
          end else begin
            w_pc_en      = 1'b1;
            w_state_next = StFetch;
          end
        end else if (w_expired) begin
          w_state_next = StErr;
        end
      end

      StWb: begin
        w_we_regs    = 1'b1;
        w_pc_en      = 1'b1;
        w_state_next = StFetch;
      end

      // Terminal: only RST leaves ERR; all requests and enables stay low.
      StErr: begin
        w_state_next = StErr;
      end

      default: begin
        w_state_next = StFetch;
      end
    endcase
  end

  // Reset masks every request/enable immediately, even mid-wait.
  assign bus.IMEM_REQ = w_imem_req & ~RST;
  assign bus.DMEM_REQ = w_dmem_req & ~RST;
  assign bus.DMEM_WE  = w_dmem_we  & ~RST;
  assign IR_EN        = w_ir_en    & ~RST;
  assign MDR_EN       = w_mdr_en   & ~RST;
  assign PC_EN        = w_pc_en    & ~RST;
  assign WE_Regs      = w_we_regs  & ~RST;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter (natural 16-bit wrap)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instret <= 16'd0;
    end else if (w_pc_en) begin
      r_instret <= r_instret + 16'd1;
    end
  end

  assign INSTRET = r_instret;

  // ---------------------------------------------------------------------------
  // Optional bus watchdog
  // ---------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
  logic r_entry;
  logic r_bus_err;
  logic w_busy;
  logic w_ack;

  assign w_busy = (r_state == StFetch) | (r_state == StMem);
  assign w_ack  = (r_state == StFetch) ? bus.IMEM_ACK : bus.DMEM_ACK;

  // High in the first cycle spent in any state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_entry <= 1'b1;
    end else begin
      r_entry <= (w_state_next != r_state);
    end
  end

  bus_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_bus_timeout (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_start   (r_entry),
    .i_busy    (w_busy),
    .i_ack     (w_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bus_err <= 1'b0;
    end else if (w_state_next == StErr) begin
      r_bus_err <= 1'b1;
    end
  end

  assign BUS_ERR = r_bus_err;
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign BUS_ERR          = 1'b0;
  assign w_unused_timeout = ^8'(TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboarded bench for multicycle_sequencer. Stimulus pushes the expected output
// events (relative cycle + enable/request pattern) of each instruction; a negedge
// monitor pops and compares whenever any enable pulse or DMEM_REQ is visible.
module tb_multicycle_sequencer;
  import proc_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  opcode;
  logic        WE_Data_in;
  logic        RE_Data_in;
  logic        WE_Regs_in;
  logic        IR_EN;
  logic        MDR_EN;
  logic        PC_EN;
  logic        WE_Regs;
  logic [15:0] INSTRET;
  logic        BUS_ERR;

  multicycle_sequencer_if bus_if ();

  multicycle_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .opcode     (opcode),
    .WE_Data_in (WE_Data_in),
    .RE_Data_in (RE_Data_in),
    .WE_Regs_in (WE_Regs_in),
    .bus        (bus_if),
    .IR_EN      (IR_EN),
    .MDR_EN     (MDR_EN),
    .PC_EN      (PC_EN),
    .WE_Regs    (WE_Regs),
    .INSTRET    (INSTRET),
    .BUS_ERR    (BUS_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   cyc;
    logic ir;
    logic mdr;
    logic pc;
    logic wer;
    logic dreq;
    logic dwe;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         m_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [15:0] exp_instret;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  function automatic void ev(input int c, input logic ir, input logic mdr, input logic pc,
                             input logic wer, input logic dreq, input logic dwe);
    ev_t x;
    x.cyc = c; x.ir = ir; x.mdr = mdr; x.pc = pc; x.wer = wer; x.dreq = dreq; x.dwe = dwe;
    exp_q.push_back(x);
  endfunction

  // Monitor
  always @(negedge CLK) begin
    chk("req_exclusive", 32'(bus_if.IMEM_REQ & bus_if.DMEM_REQ), 32'd0);
    if (IR_EN | MDR_EN | PC_EN | WE_Regs | bus_if.DMEM_REQ) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: rel cycle %0d outputs ir/mdr/pc/wer/dreq/dwe=%b, none required",
                 cyc - t0, {IR_EN, MDR_EN, PC_EN, WE_Regs, bus_if.DMEM_REQ, bus_if.DMEM_WE});
      end else begin
        m_e = exp_q.pop_front();
        chk("event_cycle", 32'(cyc - t0), 32'(m_e.cyc));
        chk("event_outputs", 32'({IR_EN, MDR_EN, PC_EN, WE_Regs, bus_if.DMEM_REQ, bus_if.DMEM_WE}),
            32'({m_e.ir, m_e.mdr, m_e.pc, m_e.wer, m_e.dreq, m_e.dwe}));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    exp_instret = 16'd0;
  endtask

  // Entered and left at posedge+1 of a FETCH cycle. With noise set, strobes are inverted
  // and stray ACKs driven where the sequencer must ignore them.
  task automatic run_instr(input logic [6:0] op, input logic wd, input logic rd,
                           input logic wr, input int iw, input int dw, input bit noise);
    opcode = op;
    {WE_Data_in, RE_Data_in, WE_Regs_in} = noise ? ~{wd, rd, wr} : {wd, rd, wr};
    bus_if.DMEM_ACK = noise;
    t0 = cyc;
    for (int k = 0; k <= iw; k++) begin
      bus_if.IMEM_ACK = (k == iw);
      step();
    end
    bus_if.IMEM_ACK = noise;          // DECODE
    step();
    {WE_Data_in, RE_Data_in, WE_Regs_in} = {wd, rd, wr};  // EXEC
    bus_if.DMEM_ACK = 1'b0;
    step();
    bus_if.IMEM_ACK = 1'b0;
    if (wd | rd) begin
      for (int k = 0; k <= dw; k++) begin
        bus_if.DMEM_ACK = (k == dw);
        step();
      end
      bus_if.DMEM_ACK = 1'b0;
    end
    if ((wd | rd) ? rd : wr) step();  // WB
  endtask

  task automatic after_instr(input string name);
    exp_instret = exp_instret + 16'd1;
    chk({name, "_instret"}, 32'(INSTRET), 32'(exp_instret));
    chk({name, "_fetch_req"}, 32'(bus_if.IMEM_REQ), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    opcode = 7'd0;
    {WE_Data_in, RE_Data_in, WE_Regs_in} = 3'b000;
    bus_if.IMEM_ACK = 1'b0;
    bus_if.DMEM_ACK = 1'b0;
    exp_instret = 16'd0;

    // Reset state: everything held low while RST is high
    step();
    step();
    chk("reset_outputs", 32'({bus_if.IMEM_REQ, bus_if.DMEM_REQ, bus_if.DMEM_WE, IR_EN, MDR_EN,
                              PC_EN, WE_Regs, BUS_ERR}), 32'd0);
    chk("reset_instret", 32'(INSTRET), 32'd0);
    RST = 1'b0;
    #1;
    chk("first_fetch_req", 32'(bus_if.IMEM_REQ), 32'd1);

    // ADD, zero-wait fetch: IR_EN c0, WB c3
    ev(0, 1, 0, 0, 0, 0, 0);
    ev(3, 0, 0, 1, 1, 0, 0);
    run_instr(OP_R, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    after_instr("add");

    // LW, DMEM_ACK on third MEM cycle: DMEM_REQ c3-c5, MDR_EN c5, WB c6
    ev(0, 1, 0, 0, 0, 0, 0);
    ev(3, 0, 0, 0, 0, 1, 0);
    ev(4, 0, 0, 0, 0, 1, 0);
    ev(5, 0, 1, 0, 0, 1, 0);
    ev(6, 0, 0, 1, 1, 0, 0);
    run_instr(OP_LOAD, 1'b0, 1'b1, 1'b1, 0, 2, 1'b0);
    after_instr("lw");

    // SW, zero-wait DMEM_ACK: DMEM_WE and PC_EN c3
    ev(0, 1, 0, 0, 0, 0, 0);
    ev(3, 0, 0, 1, 0, 1, 1);
    run_instr(OP_STORE, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    after_instr("sw");

    // Unrecognised opcode with zero strobes: PC_EN in EXEC (c2)
    ev(0, 1, 0, 0, 0, 0, 0);
    ev(2, 0, 0, 1, 0, 0, 0);
    run_instr(7'b1111111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    after_instr("unknown_op");

    // BRANCH with strobes/ACKs toggling outside EXEC/MEM: still a plain no-op
    ev(0, 1, 0, 0, 0, 0, 0);
    ev(2, 0, 0, 1, 0, 0, 0);
    run_instr(OP_BRANCH, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    after_instr("branch_noise");

    // ADDI with 3 fetch wait cycles plus noise: IR_EN c3, WB c6
    ev(3, 1, 0, 0, 0, 0, 0);
    ev(6, 0, 0, 1, 1, 0, 0);
    run_instr(OP_I, 1'b0, 1'b0, 1'b1, 3, 0, 1'b1);
    after_instr("addi_wait");

    // LW, one fetch wait and zero-wait data: IR_EN c1, MDR_EN c4, WB c5
    ev(1, 1, 0, 0, 0, 0, 0);
    ev(4, 0, 1, 0, 0, 1, 0);
    ev(5, 0, 0, 1, 1, 0, 0);
    run_instr(OP_LOAD, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
    after_instr("lw_fast");

    // RST during MEM wait (c4): DMEM_REQ dropped in c4, FETCH in c5, INSTRET cleared
    ev(0, 1, 0, 0, 0, 0, 0);
    ev(3, 0, 0, 0, 0, 1, 0);
    opcode = OP_LOAD;
    {WE_Data_in, RE_Data_in, WE_Regs_in} = 3'b011;
    t0 = cyc;
    bus_if.IMEM_ACK = 1'b1;
    step();
    bus_if.IMEM_ACK = 1'b0;
    step();
    step();
    step();
    RST = 1'b1;
    #1;
    chk("rst_mid_mem_dmem_req", 32'(bus_if.DMEM_REQ), 32'd0);
    step();
    RST = 1'b0;
    #1;
    chk("rst_mid_mem_fetch_req", 32'(bus_if.IMEM_REQ), 32'd1);
    chk("rst_mid_mem_instret", 32'(INSTRET), 32'd0);
    exp_instret = 16'd0;

    // INSTRET wrap: counter stands at 0xFFFF as if 65535 no-ops had retired
    force dut.r_instret = 16'hFFFF;
    #1;
    release dut.r_instret;
    exp_instret = 16'hFFFF;
    ev(0, 1, 0, 0, 0, 0, 0);
    ev(2, 0, 0, 1, 0, 0, 0);
    run_instr(OP_JAL, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    after_instr("wrap");

`ifdef BUS_TIMEOUT_EN
    // ACK on the 15th waiting cycle beats the timeout
    ev(14, 1, 0, 0, 0, 0, 0);
    ev(17, 0, 0, 1, 1, 0, 0);
    run_instr(OP_R, 1'b0, 1'b0, 1'b1, 14, 0, 1'b0);
    after_instr("ack_wins");

    // No ACK: ERR from c15, BUS_ERR sticky, late ACK ignored
    bus_if.IMEM_ACK = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 14; k++) step();
    chk("timeout_c14_req", 32'({bus_if.IMEM_REQ, BUS_ERR}), 32'b10);
    step();
    chk("timeout_c15_bus_err", 32'(BUS_ERR), 32'd1);
    chk("timeout_c15_imem_req", 32'(bus_if.IMEM_REQ), 32'd0);
    bus_if.IMEM_ACK = 1'b1;
    step();
    step();
    chk("err_sticky", 32'({BUS_ERR, bus_if.IMEM_REQ, IR_EN}), 32'b100);
    bus_if.IMEM_ACK = 1'b0;
    do_reset();
    #1;
    chk("err_cleared", 32'({BUS_ERR, bus_if.IMEM_REQ}), 32'b01);
`else
    // No ACK: the fetch waits indefinitely and BUS_ERR never rises
    bus_if.IMEM_ACK = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 100; k++) step();
    chk("no_timeout_c100_req", 32'(bus_if.IMEM_REQ), 32'd1);
    chk("no_timeout_bus_err", 32'(BUS_ERR), 32'd0);
    do_reset();
`endif

    // Sequencer still healthy after reset
    ev(0, 1, 0, 0, 0, 0, 0);
    ev(3, 0, 0, 1, 0, 1, 1);
    run_instr(OP_STORE, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    after_instr("sw_after_reset");

    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 15, unacknowledged-request cycles before bus error (range 1..255, 8-bit counter).
REQ-002 Port: CLK  in  1  single system clock; all state changes on rising edge.
REQ-003 Port: RST  in  1  reset; synchronous and active-high.
REQ-004 Port: opcode  in  7  opcode field of the instruction register.
REQ-005 Port: WE_Data_in, RE_Data_in, WE_Regs_in  in  1 each  decoded strobes from the control unit.
REQ-006 Port: IMEM_REQ out 1, IMEM_ACK in 1  instruction-memory request/acknowledge.
REQ-007 Port: DMEM_REQ out 1, DMEM_WE out 1, DMEM_ACK in 1  data-memory request, write qualifier, acknowledge.
REQ-008 Port: IR_EN, MDR_EN, PC_EN, WE_Regs  out 1 each  instruction-register load, load-data latch, PC update, register-file write.
REQ-009 Port: INSTRET  out 16  retired-instruction count; BUS_ERR out 1  sticky bus error.

Function
REQ-010 The block SHALL implement states FETCH, DECODE, EXEC, MEM, WB, ERR.
REQ-011 FETCH SHALL hold IMEM_REQ=1 until IMEM_ACK=1; on that cycle IR_EN=1 and next state is DECODE.
REQ-012 DECODE SHALL last exactly one cycle, then EXEC.
REQ-013 EXEC SHALL last one cycle: WE_Data_in|RE_Data_in -> MEM; else WE_Regs_in -> WB; else PC_EN=1 and -> FETCH.
REQ-014 MEM SHALL hold DMEM_REQ=1, DMEM_WE=WE_Data_in until DMEM_ACK=1; on ack: RE_Data_in -> MDR_EN=1, next WB; else PC_EN=1, next FETCH.
REQ-015 WB SHALL last one cycle with WE_Regs=1 and PC_EN=1, then FETCH.
REQ-016 ACK in the first cycle of a request SHALL be accepted (zero-wait); ACK while the matching REQ is 0 SHALL be ignored.
REQ-017 IMEM_REQ and DMEM_REQ SHALL never be 1 in the same cycle.
REQ-018 IR_EN, MDR_EN, PC_EN, WE_Regs SHALL be single-cycle pulses, decoded combinationally from state and ACK.
REQ-019 Unrecognised opcodes SHALL be sequenced as no-ops (EXEC -> PC_EN, FETCH) provided all three strobes are 0.
REQ-020 INSTRET SHALL increment by 1 on the edge ending each PC_EN cycle, wrapping 0xFFFF -> 0x0000.
REQ-021 Strobe inputs SHALL be sampled only in EXEC and MEM; changes elsewhere have no effect.

Reset
REQ-022 On an edge with RST=1: state <= FETCH, INSTRET <= 0, wait counter <= 0, BUS_ERR <= 0.
REQ-023 While RST=1 all REQ and enable outputs SHALL be forced to 0 combinationally, including mid-FETCH/MEM.
REQ-024 First cycle after RST falls SHALL be FETCH with IMEM_REQ=1.

Configuration
REQ-025 Macro BUS_TIMEOUT_EN defined: wait counter counts consecutive FETCH/MEM cycles with REQ=1, ACK=0; cleared on state entry; at TIMEOUT_CYC consecutive such cycles -> ERR; ACK in that cycle wins.
REQ-026 In ERR: BUS_ERR=1, all REQ/enable outputs 0, exit only via RST.
REQ-027 Macro undefined: no counter, ERR unreachable, BUS_ERR tied 0, unbounded waits.

Structure
REQ-028 Shared package proc_pkg SHALL hold the state encoding (3-bit localparams) and opcode constants (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111).
REQ-029 Timeout logic SHALL be one sub-module bus_timeout (start, busy, ack -> expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-030 ADD (0110011, WE_Regs_in=1), IMEM_ACK=1 at cycle 0 -> IR_EN c0, WE_Regs+PC_EN c3, FETCH c4, INSTRET=1.
REQ-031 LW (0000011, RE_Data_in=WE_Regs_in=1), DMEM_ACK at 3rd MEM cycle -> DMEM_REQ c3-c5, DMEM_WE=0, MDR_EN c5, WB c6, FETCH c7.
REQ-032 SW (0100011, WE_Data_in=1), zero-wait DMEM_ACK -> DMEM_WE=1 c3, PC_EN c3, no WE_Regs, FETCH c4.
REQ-033 RST=1 during MEM wait (c4) -> DMEM_REQ=0 in c4, FETCH c5 after RST falls, INSTRET=0.
REQ-034 BUS_TIMEOUT_EN, TIMEOUT_CYC=15, IMEM_ACK held 0 -> ERR at c15, BUS_ERR=1, IMEM_REQ=0; undefined: IMEM_REQ stays 1 at c100.
REQ-035 INSTRET preloaded by 65535 no-op retirements -> next PC_EN wraps INSTRET to 0x0000.
